mux_scan_n: RTL and testbench

- Parametrised N:1 registered multiplexer with a valid/ready output stage.
- Successor to the combinational mux2/mux4/mux8 cells.
- Two modes:
  - fixed-select: software-loaded select register.
  - scan: round-robin over all requesting channels.
- Sits between multi-channel sources and a single downstream consumer. Reports which channel won each transfer.

---
 rtl/mux_scan_n.sv | 122 ++++++++++++
 tb/tb_mux_scan_n.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mux_scan_n.sv
// N:1 registered multiplexer with fixed-select and round-robin scan modes, valid/ready output.
// Optional stall counter output enabled by defining MUX_STALL_CNT_EN.

module mux_scan_lane #(
  parameter int W     = 1,
  parameter int SEL_W = 3,
  parameter int K     = 0
) (
  input  logic [W-1:0]     d,
  input  logic             grant,
  input  logic [SEL_W-1:0] win_ch,
  output logic             ack,
  output logic [W-1:0]     d_sel
);
  logic hit;
  assign hit   = grant && (win_ch == SEL_W'(K));
  assign ack   = hit;
  // AND-OR mux leg: only the winning lane drives non-zero data
  assign d_sel = hit ? d : '0;
endmodule

module mux_scan_n #(
  parameter int N_CH  = 8,
  parameter int W     = 1,
  parameter int SEL_W = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_CH*W-1:0] d_in,
  input  logic [N_CH-1:0]   in_valid,
  output logic [N_CH-1:0]   in_ack,
  input  logic              mode,
  input  logic [SEL_W-1:0]  sel,
  input  logic              load_sel,
  output logic [W-1:0]      out_data,
  output logic [SEL_W-1:0]  out_ch,
  output logic              out_valid,
  input  logic              out_ready
`ifdef MUX_STALL_CNT_EN
  ,
  output logic [15:0]       stall_cnt
`endif
);

  logic [SEL_W-1:0] sel_q, last_q;
  logic [SEL_W-1:0] scan_ch, win_ch, idx;
  logic             scan_found, fix_found, cand, slot_free, capture;
  logic [N_CH-1:0][W-1:0] lane_d;
  logic [W-1:0]     mux_data;

  assign slot_free = !out_valid || out_ready;

  // Circular search starting one past the last winner
  always_comb begin
    scan_found = 1'b0;
    scan_ch    = '0;
    idx        = '0;
    for (int i = 1; i <= N_CH; i++) begin
      idx = SEL_W'((int'(last_q) + i) % N_CH);
      if (!scan_found && in_valid[idx]) begin
        scan_found = 1'b1;
        scan_ch    = idx;
      end
    end
  end

  assign fix_found = in_valid[sel_q];
  assign cand      = mode ? scan_found : fix_found;
  assign win_ch    = mode ? scan_ch : sel_q;
  // Gate with rst_n so no ack escapes while reset is held
  assign capture   = rst_n && slot_free && cand;

  for (genvar k = 0; k < N_CH; k++) begin : g_lane
    mux_scan_lane #(.W(W), .SEL_W(SEL_W), .K(k)) u_lane (
      .d      (d_in[k*W +: W]),
      .grant  (capture),
      .win_ch (win_ch),
      .ack    (in_ack[k]),
      .d_sel  (lane_d[k])
    );
  end

  always_comb begin
    mux_data = '0;
    for (int k = 0; k < N_CH; k++) mux_data = mux_data | lane_d[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_ch    <= '0;
      out_valid <= 1'b0;
      sel_q     <= '0;
      last_q    <= SEL_W'(N_CH - 1);
    end else begin
      if (load_sel)
        sel_q <= (int'(sel) >= N_CH) ? SEL_W'(N_CH - 1) : sel;
      if (slot_free) begin
        if (capture) begin
          out_data  <= mux_data;
          out_ch    <= win_ch;
          out_valid <= 1'b1;
          if (mode) last_q <= win_ch;
        end else begin
          out_valid <= 1'b0;
        end
      end
    end
  end

`ifdef MUX_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      stall_cnt <= '0;
    else if (load_sel)
      stall_cnt <= '0;
    else if (out_valid && !out_ready && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_mux_scan_n.sv
// Randomized scoreboard bench for mux_scan_n: stimulus pushes expected words, monitor pops on acceptance.
// Stall-counter checks are compiled in when MUX_STALL_CNT_EN is defined.

module tb_mux_scan_n;
  localparam int N  = 8;
  localparam int WD = 4;
  localparam int SW = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [N*WD-1:0] d_in = '0;
  logic [N-1:0]    in_valid = '0, in_ack;
  logic            mode = 1'b0, load_sel = 1'b0, out_ready = 1'b1;
  logic [SW-1:0]   sel = '0;
  logic [WD-1:0]   out_data;
  logic [SW-1:0]   out_ch;
  logic            out_valid;

  // second instance with a non-power-of-two channel count exercises sel clamping
  logic [23:0]     c_d;
  logic [5:0]      c_ack;
  logic [2:0]      c_sel = '0;
  logic            c_load = 1'b0;
  logic [3:0]      c_data;
  logic [2:0]      c_ch;
  logic            c_valid;

`ifdef MUX_STALL_CNT_EN
  logic [15:0] stall_cnt, c_stall;
`endif

  mux_scan_n #(.N_CH(N), .W(WD)) dut (
    .clk(clk), .rst_n(rst_n), .d_in(d_in), .in_valid(in_valid), .in_ack(in_ack),
    .mode(mode), .sel(sel), .load_sel(load_sel), .out_data(out_data), .out_ch(out_ch),
    .out_valid(out_valid), .out_ready(out_ready)
`ifdef MUX_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  mux_scan_n #(.N_CH(6), .W(4)) u_c (
    .clk(clk), .rst_n(rst_n), .d_in(c_d), .in_valid(6'h3F), .in_ack(c_ack),
    .mode(1'b0), .sel(c_sel), .load_sel(c_load), .out_data(c_data), .out_ch(c_ch),
    .out_valid(c_valid), .out_ready(1'b1)
`ifdef MUX_STALL_CNT_EN
    , .stall_cnt(c_stall)
`endif
  );

  typedef struct packed {
    logic [SW-1:0] ch;
    logic [WD-1:0] data;
  } word_t;

  word_t    q[$];
  word_t    pend;
  bit       pend_v = 0;
  int       total = 0, bad = 0;
  int       m_sel = 0, m_last = N - 1;
  int       stall_vis = 0, stall_nxt = 0;
  logic [N-1:0] exp_ack = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  // One bus cycle: drive inputs and predict this cycle's capture from the rules
  task automatic step(input logic [N-1:0] v, input logic [N*WD-1:0] d, input logic md,
                      input logic [SW-1:0] s, input logic ld, input logic rdy);
    int c;
    @(posedge clk); #2;
    if (pend_v) begin q.push_back(pend); pend_v = 0; end
    stall_vis = stall_nxt;
    in_valid = v; d_in = d; mode = md; sel = s; load_sel = ld; out_ready = rdy;
    c = -1;
    if (q.size() == 0 || rdy) begin
      if (!md) begin
        if (v[m_sel]) c = m_sel;
      end else begin
        for (int i = 1; i <= N; i++) begin
          int j;
          j = (m_last + i) % N;
          if (v[j]) begin c = j; break; end
        end
      end
    end
    exp_ack = '0;
    if (c >= 0) begin
      exp_ack[c] = 1'b1;
      pend.ch    = c[SW-1:0];
      pend.data  = d[c*WD +: WD];
      pend_v     = 1;
      if (md) m_last = c;
    end
    if (ld) stall_nxt = 0;
    else if (q.size() != 0 && !rdy && stall_nxt < 65535) stall_nxt++;
    if (ld) m_sel = (int'(s) >= N) ? N - 1 : int'(s);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    if (pend_v) begin q.push_back(pend); pend_v = 0; end
    stall_vis = stall_nxt;
    in_valid = '0; load_sel = 1'b0; out_ready = 1'b1; exp_ack = '0;
    #4 rst_n = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_ch", 32'(out_ch), 32'd0);
    chk("rst_ack", 32'(in_ack), 32'd0);
    q.delete(); pend_v = 0;
    m_sel = 0; m_last = N - 1; stall_vis = 0; stall_nxt = 0;
    repeat (2) @(posedge clk);
    #6 rst_n = 1'b1;
  endtask

  // Monitor: compares the presented word against the scoreboard head, pops on acceptance
  initial begin
    word_t h;
    forever begin
      @(posedge clk); #4;
      chk("valid", 32'(out_valid), 32'(q.size() != 0));
      if (out_valid && q.size() != 0) begin
        h = q[0];
        chk("out_ch", 32'(out_ch), 32'(h.ch));
        chk("out_data", 32'(out_data), 32'(h.data));
        if (out_ready) void'(q.pop_front());
      end
      chk("in_ack", 32'(in_ack), 32'(exp_ack));
`ifdef MUX_STALL_CNT_EN
      chk("stall_cnt", 32'(stall_cnt), 32'(stall_vis));
`endif
    end
  end

  initial begin
    for (int k = 0; k < 6; k++) c_d[k*4 +: 4] = 4'(k + 9);
    #3;
    chk("init_valid", 32'(out_valid), 32'd0);
    chk("init_ack", 32'(in_ack), 32'd0);
    chk("init_ch", 32'(out_ch), 32'd0);
    @(posedge clk); #6 rst_n = 1'b1;

    // fixed select
    step(8'h00, 32'h0, 1'b0, 3'd3, 1'b1, 1'b1);
    step(8'h08, 32'h0000_A000, 1'b0, 3'd0, 1'b0, 1'b1);
    step(8'h10, 32'h0007_0000, 1'b0, 3'd0, 1'b0, 1'b1);
    step(8'h00, 32'h0, 1'b0, 3'd0, 1'b0, 1'b1);
    // scan round-robin from reset: 0,2,5,7,0,2
    for (int i = 0; i < 6; i++) step(8'hA5, $urandom, 1'b1, 3'd0, 1'b0, 1'b1);
    // backpressure after a ch2 capture, then release
    step(8'h04, $urandom, 1'b1, 3'd0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(8'hA5, $urandom, 1'b1, 3'd0, 1'b0, 1'b0);
    step(8'hA5, $urandom, 1'b1, 3'd0, 1'b0, 1'b1);
    step(8'h00, 32'h0, 1'b1, 3'd0, 1'b1, 1'b1);
    // wrap: ch7 wins, then ch0 beats ch7
    step(8'h80, $urandom, 1'b1, 3'd0, 1'b0, 1'b1);
    step(8'h81, $urandom, 1'b1, 3'd0, 1'b0, 1'b1);
    // reset while a word is held
    step(8'h81, $urandom, 1'b1, 3'd0, 1'b0, 1'b0);
    do_reset();
    step(8'hA5, $urandom, 1'b1, 3'd0, 1'b0, 1'b1);

    for (int i = 0; i < 600; i++) begin
      logic [N-1:0] v;
      v = N'($urandom);
      if ($urandom_range(0, 3) == 0) v = '0;
      if (i == 300) do_reset();
      step(v, $urandom, 1'($urandom_range(0, 2) != 0), 3'($urandom),
           1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 9) < 7));
    end
    for (int i = 0; i < 3; i++) step(8'h00, 32'h0, 1'b1, 3'd0, 1'b0, 1'b1);
    chk("drained", 32'(q.size() + int'(pend_v)), 32'd0);

    // clamp on the 6-channel instance: sel 6 and 7 select ch5
    for (int s = 0; s < 8; s++) begin
      @(posedge clk); #2 c_sel = 3'(s); c_load = 1'b1;
      @(posedge clk); #2 c_load = 1'b0;
      @(posedge clk); #4;
      chk("clamp_ch", 32'(c_ch), 32'((s > 5) ? 5 : s));
      chk("clamp_data", 32'(c_data), 32'(((s > 5) ? 5 : s) + 9));
      chk("clamp_valid", 32'(c_valid), 32'd1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
